// File: rtl/spi_feeder_pkg.sv
// Shared types and constants for the SPI sample feeder.
// SPI_FEEDER_EMPTY_MARK_EN selects the word sent on an underrun:
// 16'hFFFF when defined (an obvious marker for the Pi), 16'h0000 otherwise.
package spi_feeder_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    BUSY,
    DRAIN
  } feeder_state_e;

`ifdef SPI_FEEDER_EMPTY_MARK_EN
  localparam logic [DATA_W-1:0] EMPTY_WORD = 16'hFFFF;
`else
  localparam logic [DATA_W-1:0] EMPTY_WORD = 16'h0000;
`endif

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO: DEPTH words of DATA_W bits, first-word-fall-through read port.
// Push and pop in the same cycle both take effect; the caller gates push with
// full and pop with empty.
module sample_fifo
  import spi_feeder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Storage write; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_sample_feeder.sv
// SPI sample feeder: buffers ADC samples and hands them one per frame to an
// SPI slave clocked by the Pi. cs and ready_for_data are synchronized into clk.
// SPI_FEEDER_EMPTY_MARK_EN chooses the underrun word (see spi_feeder_pkg).
module spi_sample_feeder
  import spi_feeder_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [DATA_W-1:0]       sample_data,
  output logic                    sample_ready,
  input  logic                    cs,
  input  logic                    ready_for_data,
  output logic [DATA_W-1:0]       unprocessed_MISO,
  output logic                    data_avail,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] rfd_sync;
  logic                   cs_d;
  logic                   rfd_d;
  logic                   cs_s;
  logic                   rfd_s;
  logic                   cs_rise;
  logic                   cs_fall;
  logic                   rfd_rise;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [DATA_W-1:0]      fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;

  feeder_state_e          state;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign rfd_s    = rfd_sync[SYNC_STAGES-1];
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign rfd_rise = rfd_s & ~rfd_d;

  assign sample_ready = ~fifo_full;
  assign fifo_push    = sample_valid & ~fifo_full;
  assign fifo_pop     = (state == IDLE) & cs_s & ~fifo_empty;

  // Synchronizers and edge-detect flops; cs resets high so release never looks like a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync  <= '1;
      rfd_sync <= '0;
      cs_d     <= 1'b1;
      rfd_d    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      rfd_sync <= {rfd_sync[SYNC_STAGES-2:0], ready_for_data};
      cs_d     <= cs_s;
      rfd_d    <= rfd_s;
    end
  end

  sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (sample_data),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky drop flag: any sample offered while the FIFO is full is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (sample_valid && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // Frame FSM: loads the output word only in IDLE, keeps it through aborted frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      unprocessed_MISO <= '0;
      data_avail       <= 1'b0;
    end else begin
      data_avail <= (fifo_count != '0) || (state == LOADED);
      case (state)
        IDLE: begin
          if (cs_fall) begin
            unprocessed_MISO <= EMPTY_WORD;
            state            <= BUSY;
          end else if (fifo_pop) begin
            unprocessed_MISO <= fifo_head;
            state            <= LOADED;
          end
        end
        LOADED: begin
          if (cs_fall) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (rfd_rise) begin
            state <= DRAIN;
          end else if (cs_rise) begin
            state <= LOADED;
          end
        end
        DRAIN: begin
          if (cs_rise) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sample_feeder.sv
// Self-checking bench for spi_sample_feeder. A frame-level model (queue of
// buffered words plus the word waiting for the Pi) predicts the settled outputs;
// literal checks pin the model at key points.
module tb_spi_sample_feeder;

  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

`ifdef SPI_FEEDER_EMPTY_MARK_EN
  localparam logic [15:0] EMPTY = 16'hFFFF;
`else
  localparam logic [15:0] EMPTY = 16'h0000;
`endif

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic        cs;
  logic        ready_for_data;
  logic [15:0] unprocessed_MISO;
  logic        data_avail;
  logic [4:0]  fifo_count;
  logic        overflow;

  int          checks = 0;
  int          errors = 0;

  // Model state
  logic [15:0] q[$];
  bit          loaded;
  logic [15:0] expMiso;
  bit          expOverflow;
  bit          modelValid;
  logic [15:0] frameMiso;

  spi_sample_feeder #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_valid     (sample_valid),
    .sample_data      (sample_data),
    .sample_ready     (sample_ready),
    .cs               (cs),
    .ready_for_data   (ready_for_data),
    .unprocessed_MISO (unprocessed_MISO),
    .data_avail       (data_avail),
    .fifo_count       (fifo_count),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // If nothing is waiting for the Pi and words are buffered, the head moves out.
  function automatic void modelSettle();
    if (!loaded && q.size() != 0) begin
      expMiso = q.pop_front();
      loaded  = 1'b1;
    end
  endfunction

  function automatic void modelPush(input logic [15:0] w);
    if (q.size() < DEPTH) q.push_back(w);
    else expOverflow = 1'b1;
  endfunction

  // Completed frame consumes the presented word; an aborted one keeps it for resend.
  function automatic void modelFrame(input bit withRfd);
    if (!loaded) expMiso = EMPTY;
    loaded = withRfd ? 1'b0 : 1'b1;
  endfunction

  function automatic void modelReset();
    q.delete();
    loaded      = 1'b0;
    expMiso     = 16'h0000;
    expOverflow = 1'b0;
  endfunction

  // Per-cycle comparison against the model whenever the outputs are settled.
  always @(negedge clk) begin
    if (modelValid && !rst) begin
      checkOutput("model_count", 32'(fifo_count), q.size());
      checkOutput("model_ready", 32'(sample_ready), (q.size() < DEPTH) ? 1 : 0);
      checkOutput("model_overflow", 32'(overflow), 32'(expOverflow));
      checkOutput("model_avail", 32'(data_avail), (q.size() != 0 || loaded) ? 1 : 0);
      checkOutput("model_miso", 32'(unprocessed_MISO), 32'(expMiso));
    end
  end

  task automatic doReset();
    modelValid = 1'b0;
    @(negedge clk);
    rst            = 1'b1;
    cs             = 1'b1;
    ready_for_data = 1'b0;
    sample_valid   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_count", 32'(fifo_count), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_avail", 32'(data_avail), 0);
    checkOutput("rst_miso", 32'(unprocessed_MISO), 0);
    checkOutput("rst_ready", 32'(sample_ready), 1);
    modelReset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    modelValid = 1'b1;
  endtask

  // Offer one sample for a single cycle.
  task automatic applyStimulus(input logic [15:0] w);
    modelValid = 1'b0;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = w;
    @(negedge clk);
    sample_valid = 1'b0;
    modelPush(w);
    modelSettle();
    repeat (4) @(negedge clk);
    modelValid = 1'b1;
  endtask

  task automatic runFrame(input bit withRfd, input bit checkLatency, input logic [15:0] latencyWord);
    logic [15:0] fw;
    modelValid = 1'b0;
    fw = loaded ? expMiso : EMPTY;
    @(negedge clk);
    cs = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
    checkOutput("frame_word", 32'(unprocessed_MISO), 32'(fw));
    frameMiso = unprocessed_MISO;
    if (withRfd) begin
      ready_for_data = 1'b1;
      repeat (4) @(negedge clk);
      ready_for_data = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    if (checkLatency) checkOutput("rise_latency", 32'(unprocessed_MISO), 32'(latencyWord));
    repeat (4) @(negedge clk);
    modelFrame(withRfd);
    modelSettle();
    modelValid = 1'b1;
  endtask

  initial begin
    rst            = 1'b1;
    cs             = 1'b1;
    ready_for_data = 1'b0;
    sample_valid   = 1'b0;
    sample_data    = 16'h0000;
    modelValid     = 1'b0;
    modelReset();
    doReset();

    // Two words: first goes straight to the output register, second waits.
    applyStimulus(16'h1234);
    applyStimulus(16'h5678);
    checkOutput("lit_first_word", 32'(unprocessed_MISO), 32'h1234);
    checkOutput("lit_count_one", 32'(fifo_count), 1);
    checkOutput("lit_avail", 32'(data_avail), 1);
    runFrame(1'b1, 1'b1, 16'h5678);
    checkOutput("lit_frame_1234", 32'(frameMiso), 32'h1234);
    checkOutput("lit_next_5678", 32'(unprocessed_MISO), 32'h5678);
    runFrame(1'b1, 1'b0, 16'h0000);

    // Aborted frame resends the same word.
    applyStimulus(16'h1234);
    applyStimulus(16'hABCD);
    runFrame(1'b0, 1'b0, 16'h0000);
    checkOutput("lit_abort_word", 32'(unprocessed_MISO), 32'h1234);
    checkOutput("lit_abort_count", 32'(fifo_count), 1);
    runFrame(1'b1, 1'b0, 16'h0000);
    checkOutput("lit_after_abort", 32'(unprocessed_MISO), 32'hABCD);

    // Push lands on the same cycle as the post-frame pop with three words queued.
    applyStimulus(16'h0011);
    applyStimulus(16'h0022);
    applyStimulus(16'h0033);
    checkOutput("lit_count_three", 32'(fifo_count), 3);
    modelValid = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
    ready_for_data = 1'b1;
    repeat (4) @(negedge clk);
    ready_for_data = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == SYNC + 1) begin
        sample_valid = 1'b1;
        sample_data  = 16'h0044;
      end
      if (k == SYNC + 2) sample_valid = 1'b0;
      checkOutput("pushpop_count", 32'(fifo_count), 3);
    end
    repeat (4) @(negedge clk);
    modelFrame(1'b1);
    modelSettle();
    modelPush(16'h0044);
    modelValid = 1'b1;
    @(negedge clk);
    checkOutput("lit_pushpop_word", 32'(unprocessed_MISO), 32'h0011);

    // Overfill: first word is loaded, DEPTH fill the FIFO, the last is dropped.
    doReset();
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(16'h0100 + 16'(i));
    checkOutput("lit_full_count", 32'(fifo_count), DEPTH);
    checkOutput("lit_full_ready", 32'(sample_ready), 0);
    checkOutput("lit_full_overflow", 32'(overflow), 1);
    checkOutput("lit_full_word", 32'(unprocessed_MISO), 32'h0100);
    for (int i = 0; i < DEPTH; i++) runFrame(1'b1, 1'b0, 16'h0000);
    checkOutput("lit_last_kept", 32'(unprocessed_MISO), 32'h0100 + DEPTH);
    checkOutput("lit_drained", 32'(fifo_count), 0);
    checkOutput("lit_overflow_sticky", 32'(overflow), 1);
    runFrame(1'b1, 1'b0, 16'h0000);

    // Underrun frame with nothing buffered.
    runFrame(1'b1, 1'b0, 16'h0000);
    checkOutput("lit_underrun_frame", 32'(frameMiso), 32'(EMPTY));
    checkOutput("lit_underrun_miso", 32'(unprocessed_MISO), 32'(EMPTY));

    // Reset in the middle of a frame with five words queued.
    for (int i = 0; i < 6; i++) applyStimulus(16'h0200 + 16'(i));
    checkOutput("lit_five_queued", 32'(fifo_count), 5);
    modelValid = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
    doReset();
    runFrame(1'b1, 1'b0, 16'h0000);
    checkOutput("lit_post_rst_underrun", 32'(frameMiso), 32'(EMPTY));
    checkOutput("lit_post_rst_count", 32'(fifo_count), 0);
    checkOutput("lit_post_rst_avail", 32'(data_avail), 0);

    modelValid = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
